// File: rtl/ram_master.sv
// Host-to-single-port-RAM master: valid/ready requests, registered-read RAM, 2-entry in-order read FIFO.
// Optional RAM_CLEAR_EN macro adds a CLEAR->RUN FSM that zeroes the RAM after every reset.
module ram_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid/payload are held by the source until that edge, ready may change freely.

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  clearing;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;

`ifdef RAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == S_CLEAR) begin
      if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= S_RUN;
      clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Reset itself must show busy = 0, so CLEAR only takes effect once rst drops.
  assign clearing = (state_q == S_CLEAR) & ~rst;
`else
  assign clearing = 1'b0;
`endif

  assign busy      = clearing;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight_q;

  // A pop this cycle already frees its slot; the in-flight read holds a reserved slot.
  assign occupancy = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign req_ready = ~rst & ~clearing & (occupancy < 3'd2);
  assign accept    = req_valid & req_ready;
  assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;

  always_comb begin
    ram_addr = req_addr;
    ram_din  = req_wdata;
    ram_we   = accept & req_we;
`ifdef RAM_CLEAR_EN
    if (clearing) begin
      ram_addr = clr_cnt_q;
      ram_din  = '0;
      ram_we   = 1'b1;
    end
`endif
  end

  always_comb begin
    inflight_d = accept & ~req_we;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) fifo_q[wr_ptr_q] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: behavioural RAM plus a memory/queue reference model.
module tb_ram_master;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we, busy;

  ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy)
  );

  // Clock / reset block and the external registered-read RAM.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] tb_ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_din;
    ram_dout <= tb_ram[ram_addr];
  end

  // Reference model and scoreboard.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            rsp_cyc_q [$];
  int            vec = 0;
  int            err = 0;
  int            cyc = 0;
  int            acc_cyc;
  bit            accepted;
  logic [DW-1:0] last_rsp;

  // One clock cycle: inputs already driven; observe handshakes, then advance to the next negedge.
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    accepted = 1'b0;
    if (req_valid && req_ready) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
      if (req_we) model_mem[req_addr] = req_wdata;
      else        exp_q.push_back(model_mem[req_addr]);
    end
    if (rsp_valid && rsp_ready) begin
      vec++;
      rsp_cyc_q.push_back(cyc);
      last_rsp = rsp_rdata;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL rsp_unexpected: got rdata=%0h with no outstanding read", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          err++;
          $display("FAIL rsp_data: got %0h expected %0h", rsp_rdata, e);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    vec++;
    if (accepted !== 1'b1) begin
      err++;
      $display("FAIL write_accept: addr %0h accepted=%0b expected 1", a, accepted);
    end
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    req_wdata = DW'($urandom_range(0, 255));
    tick();
    vec++;
    if (accepted !== 1'b1) begin
      err++;
      $display("FAIL read_accept: addr %0h accepted=%0b expected 1", a, accepted);
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    int n;
    rst = 1'b0;
    #1;
`ifdef RAM_CLEAR_EN
    n = 0;
    vec++;
    if (req_ready !== 1'b0) begin
      err++;
      $display("FAIL clear_ready: req_ready=%0b expected 0 while clearing", req_ready);
    end
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); cyc++; @(negedge clk); #1;
      n++;
    end
    vec++;
    if (n != DEPTH) begin
      err++;
      $display("FAIL clear_cycles: busy for %0d cycles expected %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`else
    n = 0;
    vec++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      err++;
      $display("FAIL post_reset: busy=%0b req_ready=%0b expected 0/1", busy, req_ready);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b1;
    req_addr = 4'd7; req_wdata = 8'h5A;
    #1;
    vec++;
    if (req_ready !== 1'b0) begin err++; $display("FAIL reset_req_ready: got %0b expected 0", req_ready); end
    vec++;
    if (rsp_valid !== 1'b0) begin err++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    vec++;
    if (rsp_rdata !== '0) begin err++; $display("FAIL reset_rsp_rdata: got %0h expected 0", rsp_rdata); end
    vec++;
    if (ram_we !== 1'b0) begin err++; $display("FAIL reset_ram_we: got %0b expected 0", ram_we); end
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    req_valid = 1'b0;
    @(posedge clk); cyc++; @(negedge clk);
    release_reset();
  endtask

  task automatic test_read_latency();
    int a0;
    rsp_ready = 1'b1;
    do_write(4'd3, 8'hA5);
    rsp_cyc_q.delete();
    do_read(4'd3);
    a0 = acc_cyc;
    for (int i = 0; i < 6 && rsp_cyc_q.size() == 0; i++) tick();
    vec++;
    if (rsp_cyc_q.size() == 0) begin
      err++; $display("FAIL latency_timeout: no response within 6 cycles");
    end else begin
      if (rsp_cyc_q[0] - a0 != 2) begin
        err++; $display("FAIL latency: got %0d cycles expected 2", rsp_cyc_q[0] - a0);
      end
      vec++;
      if (last_rsp !== 8'hA5) begin err++; $display("FAIL latency_data: got %0h expected a5", last_rsp); end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_write(AW'(i), DW'($urandom_range(0, 255)));
    idle(2);
    rsp_ready = 1'b0; req_we = 1'b0; nxt = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_addr = AW'(nxt);
      tick();
      if (accepted) nxt++;
    end
    vec++;
    if (nxt != 2) begin err++; $display("FAIL bp_accepts: got %0d expected 2", nxt); end
    #1;
    vec++;
    if (req_ready !== 1'b0) begin err++; $display("FAIL bp_ready: got %0b expected 0", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 6 && nxt < 3; i++) begin
      req_addr = AW'(nxt);
      tick();
      if (accepted) nxt++;
    end
    vec++;
    if (nxt != 3) begin err++; $display("FAIL bp_resume: third read not accepted, nxt=%0d expected 3", nxt); end
    idle(5);
    vec++;
    if (exp_q.size() != 0) begin err++; $display("FAIL bp_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_write_then_read();
    rsp_ready = 1'b1;
    do_write(4'd5, 8'h3C);
    do_read(4'd5);
    idle(4);
    vec++;
    if (last_rsp !== 8'h3C) begin err++; $display("FAIL wr_rd_same: got %0h expected 3c", last_rsp); end
  endtask

  task automatic test_stream();
    int a0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom_range(0, 255)));
    rsp_cyc_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      if (i == 0) a0 = acc_cyc;
    end
    idle(4);
    vec++;
    if (rsp_cyc_q.size() != DEPTH) begin
      err++; $display("FAIL stream_count: got %0d expected %0d", rsp_cyc_q.size(), DEPTH);
    end else begin
      if (rsp_cyc_q[0] != a0 + 2) begin
        err++; $display("FAIL stream_first: at %0d expected %0d", rsp_cyc_q[0], a0 + 2);
      end
      vec++;
      if (rsp_cyc_q[DEPTH-1] - rsp_cyc_q[0] != DEPTH - 1) begin
        err++; $display("FAIL stream_gaps: span %0d expected %0d", rsp_cyc_q[DEPTH-1] - rsp_cyc_q[0], DEPTH - 1);
      end
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b1;
    do_read(AW'($urandom_range(0, DEPTH - 1)));
    rst = 1'b1;
    #1;
    vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      err++; $display("FAIL midflight_reset: rsp_valid=%0b req_ready=%0b expected 0/0", rsp_valid, req_ready);
    end
    exp_q.delete();
    @(posedge clk); cyc++; @(negedge clk);
    release_reset();
    rsp_cyc_q.delete();
    idle(6);
    vec++;
    if (rsp_cyc_q.size() != 0) begin
      err++; $display("FAIL midflight_ghost: got %0d responses expected 0", rsp_cyc_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = DW'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rsp_ready = 1'b1;
    idle(6);
    vec++;
    if (exp_q.size() != 0) begin err++; $display("FAIL random_drain: %0d left expected 0", exp_q.size()); end
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 8'hFF);
    idle(1);
    rst = 1'b1;
    @(posedge clk); cyc++; @(negedge clk);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      do_read(AW'($urandom_range(0, DEPTH - 1)));
      idle(3);
      vec++;
      if (last_rsp !== 8'h00) begin err++; $display("FAIL clear_data: got %0h expected 00", last_rsp); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(negedge clk);
    test_reset();
    idle(1);
    test_read_latency();
    test_backpressure();
    test_write_then_read();
    test_stream();
    test_reset_midflight();
    test_random();
`ifdef RAM_CLEAR_EN
    test_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
